// File: rtl/cdb_writeback_if.sv
// cdb_writeback_if: issue, add/mul result channels, CDB broadcast and register write port
// master: drives issue and result channels, observes ready/CDB/register write/busyMask
// slave:  the writeback unit side of the same signals
interface cdb_writeback_if #(
    parameter int TAGW = 3,
    parameter int DW = 16
);
    logic            issueValid;
    logic [2:0]      issueDest;
    logic [TAGW-1:0] issueTag;
    logic            addValid;
    logic [TAGW-1:0] addTag;
    logic [DW-1:0]   addResult;
    logic            addReady;
    logic            mulValid;
    logic [TAGW-1:0] mulTag;
    logic [DW-1:0]   mulResult;
    logic            mulReady;
    logic            cdbValid;
    logic [TAGW-1:0] cdbTag;
    logic [DW-1:0]   cdbData;
    logic            regWriteEnable;
    logic [2:0]      regDataAddress;
    logic [DW-1:0]   regDataIn;
    logic [5:0]      busyMask;

    modport master (
        output issueValid, issueDest, issueTag,
        output addValid, addTag, addResult, mulValid, mulTag, mulResult,
        input  addReady, mulReady, cdbValid, cdbTag, cdbData,
        input  regWriteEnable, regDataAddress, regDataIn, busyMask
    );

    modport slave (
        input  issueValid, issueDest, issueTag,
        input  addValid, addTag, addResult, mulValid, mulTag, mulResult,
        output addReady, mulReady, cdbValid, cdbTag, cdbData,
        output regWriteEnable, regDataAddress, regDataIn, busyMask
    );
endinterface

// File: rtl/cdb_writeback.sv
// cdb_writeback: arbitrates add/mul results onto the CDB and retires them into the FP register file
// Ports: clock, reset (synchronous, active-high); bus (slave) carries the issue request,
// the add/mul result channels with ready, the CDB broadcast, the register write port and busyMask.
module cdb_writeback #(
    parameter int TAGW = 3,
    parameter int DW = 16
) (
    input logic            clock,
    input logic            reset,
    cdb_writeback_if.slave bus
);
    logic [TAGW-1:0] qi [1:6];
    logic            add_full, mul_full, ptr_mul;
    logic [TAGW-1:0] add_tag, mul_tag, win_tag;
    logic [DW-1:0]   add_data, mul_data, win_data;
    logic            win_add, win_mul, win, hit, iss, wr;
    logic [2:0]      hit_reg;

    assign bus.addReady = !add_full;
    assign bus.mulReady = !mul_full;

    always_comb begin
        win_add = add_full && (!mul_full || !ptr_mul);
        win_mul = mul_full && !win_add;
        win = win_add || win_mul;
        win_tag = win_add ? add_tag : mul_tag;
        win_data = win_add ? add_data : mul_data;
        iss = bus.issueValid && bus.issueDest >= 3'd1 && bus.issueDest <= 3'd6 && bus.issueTag != '0;
        hit = 1'b0;
        hit_reg = 3'd0;
        // descending scan leaves the lowest matching register
        for (int r = 6; r >= 1; r--) begin
            if (win && qi[r] == win_tag) begin
                hit = 1'b1;
                hit_reg = 3'(r);
            end
        end
        // a same-edge issue to the matched register takes ownership; its stale value is not written
        wr = hit && !(iss && bus.issueDest == hit_reg);
        bus.busyMask = '0;
        for (int r = 1; r <= 6; r++) bus.busyMask[r-1] = qi[r] != '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 1; r <= 6; r++) qi[r] <= '0;
            add_full <= 1'b0;
            mul_full <= 1'b0;
            ptr_mul <= 1'b0;
            bus.cdbValid <= 1'b0;
            bus.cdbTag <= '0;
            bus.cdbData <= '0;
            bus.regWriteEnable <= 1'b0;
            bus.regDataAddress <= '0;
            bus.regDataIn <= '0;
        end else begin
            for (int r = 1; r <= 6; r++) begin
                if (iss && bus.issueDest == 3'(r))
                    qi[r] <= bus.issueTag;
                else if (win && qi[r] == win_tag)
                    qi[r] <= '0;
            end
            if (win_add)
                add_full <= 1'b0;
            else if (bus.addValid && !add_full && bus.addTag != '0) begin
                add_full <= 1'b1;
                add_tag <= bus.addTag;
                add_data <= bus.addResult;
            end
            if (win_mul)
                mul_full <= 1'b0;
            else if (bus.mulValid && !mul_full && bus.mulTag != '0) begin
                mul_full <= 1'b1;
                mul_tag <= bus.mulTag;
                mul_data <= bus.mulResult;
            end
            // priority only rotates on a real conflict; an uncontested win leaves it alone
            if (add_full && mul_full) ptr_mul <= !ptr_mul;
            bus.cdbValid <= win;
            if (win) begin
                bus.cdbTag <= win_tag;
                bus.cdbData <= win_data;
            end
            bus.regWriteEnable <= wr;
            if (wr) begin
                bus.regDataAddress <= hit_reg;
                bus.regDataIn <= win_data;
            end
        end
    end
endmodule
